up_counter_sync: RTL and testbench
==================================

// Module: up_counter_sync
// PURPOSE
//   Synchronous modulo-N up counter. Counterpart to the team's 4-bit synchronous
//   down counter, in the opposite count direction. Adds count enable, parallel
//   load, terminal-count and carry outputs so that stages can be cascaded.
//   Used as a sequence/index generator in the sequential lab designs.
// PARAMETERS
//   WIDTH      4   counter width in bits (1..16)
//   MAX_COUNT  15  terminal value. Count runs 0..MAX_COUNT. Must be <= 2**WIDTH-1.
// PORTS
//   clk        in   1      rising-edge clock; the only clock
//   reset      in   1      synchronous reset, active-low (0 = reset, sampled on clk rise)
//   en         in   1      count enable
//   load       in   1      parallel load strobe
//   d          in   WIDTH  load value
//   q          out  WIDTH  registered count
//   tc         out  1      terminal count: combinational, q == MAX_COUNT
//   carry_out  out  1      combinational, tc & en & ~load; drives en of the next stage
//   wrapped    out  1      registered one-cycle pulse, asserted the cycle after q wraps MAX_COUNT->0
// BEHAVIOUR
//   - All state updates occur on the rising edge of clk. No asynchronous paths.
//   - Priority on each edge: reset (low) > load > en > hold.
//   - Reset: q=0, wrapped=0. Hence tc=(MAX_COUNT==0), carry_out=0 while load=1 or en=0.
//     Reset mid-count overrides load and en in the same cycle.
//   - Load: q <= d if d <= MAX_COUNT, else q <= MAX_COUNT (clamp). wrapped <= 0.
//     Load never asserts wrapped.
//   - Count (en=1, load=0): if q == MAX_COUNT, then q <= 0 and wrapped <= 1.
//     Otherwise q <= q+1 and wrapped <= 0.
//   - Hold (en=0, load=0): q unchanged, wrapped <= 0.
//   - Latency: q updates 1 cycle after the en/load sample. tc and carry_out follow q
//     (and en) combinationally. wrapped lags the wrap edge by 0 cycles: it is
//     registered on the same edge that writes q=0.
//   - Arithmetic: unsigned, WIDTH bits. Never exceeds MAX_COUNT. MAX_COUNT = 2**WIDTH-1
//     is a natural binary wrap. Smaller MAX_COUNT gives modulo-(MAX_COUNT+1) counting.
//   - Simultaneous load and en: load wins; the count does not advance that cycle.
//   - Cascading: stage N+1 en = stage N carry_out. The chain counts as one
//     WIDTH*k-bit counter. All stages share clk and reset.
//   - X on en or load while reset=0 must not corrupt q after reset.
// CONFIGURATION
//   UP_COUNTER_SATURATE_EN
//     defined:   at q == MAX_COUNT with en=1, q holds at MAX_COUNT (no wrap),
//                wrapped stays 0, and tc stays high until load or reset.
//                carry_out is still tc & en & ~load.
//     undefined: wrap-around as described in BEHAVIOUR (default build).
// TESTING
//   1. Reset: hold reset=0 for 2 cycles with en=1 and load=1 -> q=0, wrapped=0, carry_out=0.
//   2. Count: WIDTH=4, MAX=15, en=1 for 17 cycles from 0 -> q=1..15,0,1.
//      tc high only at q=15. wrapped pulses once, in the cycle q=0.
//   3. Modulo: MAX_COUNT=9, en=1 for 11 cycles -> q=1..9,0,1. Only one wrap.
//   4. Load/priority: q=5, load=1, d=12, en=1 -> q=12 next cycle (no increment).
//      With d=13 and MAX=9 -> q=9 (clamped).
//   5. Hold and reset mid-count: q=7, en=0 for 3 cycles -> q stays 7.
//      Then reset=0 while en=1 -> q=0 on the next edge.
//   6. Cascade and saturate: two 4-bit stages counting from 0x0F, en=1 -> 0x10.
//      With UP_COUNTER_SATURATE_EN defined and q=15, en=1 -> q stays 15, wrapped=0.

Source files
------------

// File: rtl/up_counter_sync.sv
// Synchronous modulo-(MAX_COUNT+1) up counter with enable, clamped parallel load,
// terminal count, cascade carry and wrap pulse. Define UP_COUNTER_SATURATE_EN to hold at MAX_COUNT.
module up_counter_sync #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry_out,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             wrapped_reg, wrapped_next;

  always_comb begin
    q_next       = q_reg;
    wrapped_next = 1'b0;
    if (load) begin
      // Out-of-range load values clamp so q never exceeds the terminal value
      q_next = (d > MAX_Q) ? MAX_Q : d;
    end else if (en) begin
      if (q_reg == MAX_Q) begin
`ifdef UP_COUNTER_SATURATE_EN
        q_next = MAX_Q;
`else
        q_next       = '0;
        wrapped_next = 1'b1;
`endif
      end else begin
        q_next = q_reg + 1'b1;
      end
    end
  end

  // Reset is checked first so X on en/load during reset never reaches the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg       <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign q         = q_reg;
  assign wrapped   = wrapped_reg;
  assign tc        = (q_reg == MAX_Q);
  assign carry_out = tc & en & ~load;

endmodule

// File: tb/tb_up_counter_sync.sv
// Directed bench for up_counter_sync: mod-16, mod-10 and a two-stage cascade.
// Expectations follow UP_COUNTER_SATURATE_EN when it is defined.
module tb_up_counter_sync;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int pass_count  = 0;
  int total_count = 0;

  // mod-16 instance
  logic       en_a, load_a, tc_a, carry_a, wrapped_a;
  logic [3:0] d_a, q_a;
  // mod-10 instance
  logic       en_b, load_b, tc_b, carry_b, wrapped_b;
  logic [3:0] d_b, q_b;
  // two cascaded mod-16 stages
  logic       cas_en, cas_load;
  logic [1:0] stage_en, stage_tc, stage_carry, stage_wrapped;
  logic [3:0] stage_d [0:1];
  logic [3:0] stage_q [0:1];

  up_counter_sync #(.WIDTH(4), .MAX_COUNT(15)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .load(load_a), .d(d_a),
    .q(q_a), .tc(tc_a), .carry_out(carry_a), .wrapped(wrapped_a));

  up_counter_sync #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .load(load_b), .d(d_b),
    .q(q_b), .tc(tc_b), .carry_out(carry_b), .wrapped(wrapped_b));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_en[gi] = cas_en;
      end else begin : g_next
        assign stage_en[gi] = stage_carry[gi-1];
      end
      up_counter_sync #(.WIDTH(4), .MAX_COUNT(15)) dut_c (
        .clk(clk), .reset(reset), .en(stage_en[gi]), .load(cas_load), .d(stage_d[gi]),
        .q(stage_q[gi]), .tc(stage_tc[gi]), .carry_out(stage_carry[gi]),
        .wrapped(stage_wrapped[gi]));
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    en_a = 1'b1; load_a = 1'b1; d_a = 4'd5;
    en_b = 1'b0; load_b = 1'b0; d_b = 4'd0;
    cas_en = 1'b0; cas_load = 1'b0; stage_d[0] = 4'd0; stage_d[1] = 4'd0;

    // 1. reset dominates en and load
    tick(); tick();
    check("rst_q", q_a, 0);
    check("rst_wrapped", wrapped_a, 0);
    check("rst_carry", carry_a, 0);
    check("rst_tc", tc_a, 0);
    $display("reset: q=%0d wrapped=%0b carry=%0b", q_a, wrapped_a, carry_a);
    reset = 1'b1; load_a = 1'b0; en_a = 1'b0;
    tick();
    check("hold_after_rst", q_a, 0);

    // 2. mod-16 count for 17 cycles
    en_a = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      check("cnt16_q", q_a, i % 16);
      check("cnt16_tc", tc_a, (i == 15));
      check("cnt16_carry", carry_a, (i == 15));
      check("cnt16_wrapped", wrapped_a, (i == 16));
      $display("cnt16 step %0d: q=%0d tc=%0b wrapped=%0b", i, q_a, tc_a, wrapped_a);
    end
    en_a = 1'b0;

    // 3. mod-10 count for 11 cycles
    en_b = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("cnt10_q", q_b, i % 10);
      check("cnt10_tc", tc_b, (i == 9));
      check("cnt10_wrapped", wrapped_b, (i == 10));
      $display("cnt10 step %0d: q=%0d tc=%0b wrapped=%0b", i, q_b, tc_b, wrapped_b);
    end
    en_b = 1'b0;

    // 4. load priority and clamp
    load_a = 1'b1; d_a = 4'd5;
    tick();
    check("load5", q_a, 5);
    d_a = 4'd12; en_a = 1'b1;
    tick();
    check("load12_no_inc", q_a, 12);
    check("load12_wrapped", wrapped_a, 0);
    $display("load: q=%0d", q_a);
    load_a = 1'b0; en_a = 1'b0;
    load_b = 1'b1; d_b = 4'd13;
    tick();
    check("clamp_q", q_b, 9);
    check("clamp_tc", tc_b, 1);
    en_b = 1'b1; #1;
    check("carry_blocked_by_load", carry_b, 0);
    load_b = 1'b0; #1;
    check("carry_at_tc", carry_b, 1);
    $display("clamp: q=%0d tc=%0b", q_b, tc_b);
    en_b = 1'b0;

    // 5. hold, then reset mid-count
    load_a = 1'b1; d_a = 4'd7;
    tick();
    load_a = 1'b0; en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold7", q_a, 7);
      check("hold_wrapped", wrapped_a, 0);
    end
    en_a = 1'b1; reset = 1'b0;
    tick();
    check("rst_mid", q_a, 0);
    $display("reset mid-count: q=%0d", q_a);
    reset = 1'b1; en_a = 1'b0;

    // 6a. terminal value with en: wrap or saturate
    load_a = 1'b1; d_a = 4'd15;
    tick();
    load_a = 1'b0; en_a = 1'b1;
    tick();
`ifdef UP_COUNTER_SATURATE_EN
    check("sat_q", q_a, 15);
    check("sat_wrapped", wrapped_a, 0);
    check("sat_tc", tc_a, 1);
`else
    check("wrap_q", q_a, 0);
    check("wrap_wrapped", wrapped_a, 1);
    check("wrap_tc", tc_a, 0);
`endif
    $display("terminal+en: q=%0d wrapped=%0b", q_a, wrapped_a);
    en_a = 1'b0;

    // 6b. cascade 0x0F -> 0x10 -> 0x11, then 0xFF -> 0x00
    cas_load = 1'b1; stage_d[0] = 4'hF; stage_d[1] = 4'h0;
    tick();
    check("cas_load", {stage_q[1], stage_q[0]}, 8'h0F);
    cas_load = 1'b0; cas_en = 1'b1;
    tick();
`ifdef UP_COUNTER_SATURATE_EN
    check("cas_step1", {stage_q[1], stage_q[0]}, 8'h1F);
`else
    check("cas_step1", {stage_q[1], stage_q[0]}, 8'h10);
    tick();
    check("cas_step2", {stage_q[1], stage_q[0]}, 8'h11);
    cas_en = 1'b0; cas_load = 1'b1; stage_d[0] = 4'hF; stage_d[1] = 4'hF;
    tick();
    cas_load = 1'b0; cas_en = 1'b1;
    tick();
    check("cas_rollover", {stage_q[1], stage_q[0]}, 8'h00);
    check("cas_wrapped_hi", stage_wrapped[1], 1);
`endif
    $display("cascade: q=%02h", {stage_q[1], stage_q[0]});
    cas_en = 1'b0;

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
